// File: rtl/booth_divider_pkg.sv
// Shared definitions for the booth multiplier/divider family.
//   BOOTH_W : default operand width (dividend is 2*BOOTH_W bits)
//   state_t : sequencer states shared by the multiplier and the divider
package booth_divider_pkg;

  localparam int BOOTH_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/booth_div_step.sv
// One radix-2 non-restoring division step (combinational).
//   pr_i   : partial remainder, W+1 bits, two's complement
//   bit_i  : next dividend bit shifted in from the quotient register
//   ads_i  : divisor magnitude
//   pr_o   : new partial remainder
//   qbit_o : quotient bit (1 when the new partial remainder is non-negative)
module booth_div_step
  import booth_divider_pkg::*;
#(
  parameter int W = BOOTH_W
) (
  input  logic [W:0]   pr_i,
  input  logic         bit_i,
  input  logic [W-1:0] ads_i,
  output logic [W:0]   pr_o,
  output logic         qbit_o
);

  logic [W:0] sh;

  // The partial remainder stays within [-|dvs|, |dvs|), so it fits W signed
  // bits and the top bit can be dropped by the shift.
  assign sh     = {pr_i[W-1:0], bit_i};
  assign pr_o   = pr_i[W] ? sh + {1'b0, ads_i} : sh - {1'b0, ads_i};
  assign qbit_o = ~pr_o[W];

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per clock on magnitudes, sign fix-up in a final cycle.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, sampled only while idle
//   dvd, dvs      : signed dividend (2W) and divisor (W), captured on accept
//   quo, rem      : signed quotient (toward zero) and remainder (sign of dvd)
//   busy          : high from the accept edge until the result edge
//   done          : one-cycle pulse when quo/rem/ovf/dbz are updated
//   ovf, dbz      : quotient overflow, divide by zero
module booth_divider
  import booth_divider_pkg::*;
#(
  parameter int W = BOOTH_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [2*W-1:0] dvd,
  input  logic signed [W-1:0]   dvs,
  output logic signed [W-1:0]   quo,
  output logic signed [W-1:0]   rem,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int CW = $clog2(W);

  // Magnitudes are read as unsigned, so negating the most negative value
  // yields its correct magnitude without an extra bit.
  function automatic logic [2*W-1:0] abs_dvd(input logic [2*W-1:0] v);
    return v[2*W-1] ? -v : v;
  endfunction

  function automatic logic [W-1:0] abs_dvs(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic [W-1:0] neg_if(input logic neg, input logic [W-1:0] v);
    return neg ? -v : v;
  endfunction

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     pr_q;
  logic [W-1:0]   qt_q;
  logic [W-1:0]   ads_q;
  logic [W-1:0]   dvd_lo_q;
  logic           sgn_dvd_q;
  logic           sgn_dvs_q;
  logic           hi_ovf_q;
  logic           dbz_q;

  logic [2*W-1:0] adv;
  logic [W-1:0]   ads;
  logic [W:0]     pr_d;
  logic           qbit_d;
  logic [W-1:0]   qt_d;
  logic [W-1:0]   rmag;
  logic           qneg;
  logic           ovf_rng;

  assign adv  = abs_dvd(dvd);
  assign ads  = abs_dvs(dvs);
  assign qt_d = {qt_q[W-2:0], qbit_d};

  booth_div_step #(.W(W)) u_step (
    .pr_i   (pr_q),
    .bit_i  (qt_q[W-1]),
    .ads_i  (ads_q),
    .pr_o   (pr_d),
    .qbit_o (qbit_d)
  );

  // Restore a negative final remainder; the result is < |dvs| and fits W bits.
  assign rmag = pr_q[W] ? pr_q[W-1:0] + ads_q : pr_q[W-1:0];
  assign qneg = sgn_dvd_q ^ sgn_dvs_q;
  // Negative quotients may reach 2^(W-1); positive ones stop at 2^(W-1)-1.
  assign ovf_rng = qneg ? (qt_q[W-1] & (|qt_q[W-2:0])) : qt_q[W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sgn_dvd_q <= dvd[2*W-1];
            sgn_dvs_q <= dvs[W-1];
            ads_q     <= ads;
            dvd_lo_q  <= dvd[W-1:0];
            // High half seeds the partial remainder; low half is shifted in.
            pr_q      <= {1'b0, adv[2*W-1:W]};
            qt_q      <= adv[W-1:0];
            // High half >= |dvs| means the magnitude quotient needs > W bits.
            hi_ovf_q  <= (adv[2*W-1:W] >= ads);
            dbz_q     <= (ads == '0);
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          pr_q  <= pr_d;
          qt_q  <= qt_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (dbz_q) begin
            quo <= '1;
            rem <= dvd_lo_q;
            ovf <= 1'b0;
            dbz <= 1'b1;
          end else begin
            quo <= neg_if(qneg, qt_q);
            rem <= neg_if(sgn_dvd_q, rmag);
            ovf <= hi_ovf_q | ovf_rng;
            dbz <= 1'b0;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
